// File: rtl/cmac_actv_feeder.sv
// cmac_actv_feeder: activation feeder for one MAC cell row.
// Double-buffers the kernel weight atom (shadow + active). Registers each data
// atom with its nonzero flags and issues it one cycle later, paired with the
// active weights.
module cmac_actv_feeder #(
    parameter int ATOMC = 64,
    parameter int BPE   = 8,
    parameter int CNT_W = 16
) (
    input  logic                   nvdla_core_clk,
    input  logic                   nvdla_core_rst,
    input  logic                   op_en,
    input  logic                   wt_in_pvld,
    output logic                   wt_in_prdy,
    input  logic [ATOMC*BPE-1:0]   wt_in_data,
    input  logic [ATOMC-1:0]       wt_in_mask,
    input  logic                   dat_in_pvld,
    output logic                   dat_in_prdy,
    input  logic [ATOMC*BPE-1:0]   dat_in_data,
    input  logic [ATOMC-1:0]       dat_in_mask,
    input  logic                   dat_in_stripe_end,
    output logic [ATOMC*BPE-1:0]   dat_actv_data,
    output logic [ATOMC-1:0]       dat_actv_nz,
    output logic [ATOMC-1:0]       dat_actv_pvld,
    output logic [ATOMC*BPE-1:0]   wt_actv_data,
    output logic [ATOMC-1:0]       wt_actv_nz,
    output logic [ATOMC-1:0]       wt_actv_pvld,
    output logic [CNT_W-1:0]       stripe_cnt,
    output logic                   feeder_idle
);

    localparam int DW = ATOMC * BPE;

    // An element counts as nonzero only if upstream marks it present and its value is not zero.
    function automatic logic [ATOMC-1:0] deriveNz(input logic [DW-1:0] data,
                                                  input logic [ATOMC-1:0] mask);
        logic [ATOMC-1:0] nz;
        nz = '0;
        for (int i = 0; i < ATOMC; i++) begin
            nz[i] = mask[i] & (data[i*BPE +: BPE] != '0);
        end
        return nz;
    endfunction

    logic              shdVld_q,    shdVld_d;
    logic [DW-1:0]     shdData_q,   shdData_d;
    logic [ATOMC-1:0]  shdNz_q,     shdNz_d;
    logic              actVld_q,    actVld_d;
    logic [DW-1:0]     actData_q,   actData_d;
    logic [ATOMC-1:0]  actNz_q,     actNz_d;
    logic [DW-1:0]     datOut_q,    datOut_d;
    logic [ATOMC-1:0]  datNz_q,     datNz_d;
    logic [DW-1:0]     wtOut_q,     wtOut_d;
    logic [ATOMC-1:0]  wtNz_q,      wtNz_d;
    logic              pvld_q,      pvld_d;
    logic [CNT_W-1:0]  stripeCnt_q, stripeCnt_d;

    logic wtFire;
    logic datFire;
    logic stripeDone;
    logic promote;

    // Handshakes: shadow takes a weight when empty; data is accepted only with live weights.
    always_comb begin
        wt_in_prdy  = op_en & ~shdVld_q;
        dat_in_prdy = op_en & actVld_q;
        wtFire      = wt_in_pvld & wt_in_prdy;
        datFire     = dat_in_pvld & dat_in_prdy;
        stripeDone  = datFire & dat_in_stripe_end;
        promote     = shdVld_q & (~actVld_q | stripeDone);
    end

    // Next state: shadow fill, shadow-to-active promotion, data issue and stripe counting.
    always_comb begin
        shdVld_d    = shdVld_q;
        shdData_d   = shdData_q;
        shdNz_d     = shdNz_q;
        actVld_d    = actVld_q;
        actData_d   = actData_q;
        actNz_d     = actNz_q;
        datOut_d    = datOut_q;
        datNz_d     = datNz_q;
        wtOut_d     = wtOut_q;
        wtNz_d      = wtNz_q;
        pvld_d      = 1'b0;
        stripeCnt_d = stripeCnt_q;

        if (!op_en) begin
            shdVld_d    = 1'b0;
            actVld_d    = 1'b0;
            stripeCnt_d = '0;
        end else begin
            if (wtFire) begin
                shdVld_d  = 1'b1;
                shdData_d = wt_in_data;
                shdNz_d   = deriveNz(wt_in_data, wt_in_mask);
            end else if (promote) begin
                shdVld_d  = 1'b0;
            end

            if (promote) begin
                actVld_d  = 1'b1;
                actData_d = shdData_q;
                actNz_d   = shdNz_q;
            end else if (stripeDone) begin
                actVld_d  = 1'b0;
            end

            if (datFire) begin
                pvld_d   = 1'b1;
                datOut_d = dat_in_data;
                datNz_d  = deriveNz(dat_in_data, dat_in_mask);
                wtOut_d  = actData_q;
                wtNz_d   = actNz_q;
            end

            if (stripeDone) begin
                stripeCnt_d = stripeCnt_q + CNT_W'(1);
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            shdVld_q    <= 1'b0;
            shdData_q   <= '0;
            shdNz_q     <= '0;
            actVld_q    <= 1'b0;
            actData_q   <= '0;
            actNz_q     <= '0;
            datOut_q    <= '0;
            datNz_q     <= '0;
            wtOut_q     <= '0;
            wtNz_q      <= '0;
            pvld_q      <= 1'b0;
            stripeCnt_q <= '0;
        end else begin
            shdVld_q    <= shdVld_d;
            shdData_q   <= shdData_d;
            shdNz_q     <= shdNz_d;
            actVld_q    <= actVld_d;
            actData_q   <= actData_d;
            actNz_q     <= actNz_d;
            datOut_q    <= datOut_d;
            datNz_q     <= datNz_d;
            wtOut_q     <= wtOut_d;
            wtNz_q      <= wtNz_d;
            pvld_q      <= pvld_d;
            stripeCnt_q <= stripeCnt_d;
        end
    end

    // Output drive: one shared valid fans out to every lane of both buses.
    always_comb begin
        dat_actv_data = datOut_q;
        dat_actv_nz   = datNz_q;
        dat_actv_pvld = {ATOMC{pvld_q}};
        wt_actv_data  = wtOut_q;
        wt_actv_nz    = wtNz_q;
        wt_actv_pvld  = {ATOMC{pvld_q}};
        stripe_cnt    = stripeCnt_q;
        feeder_idle   = ~shdVld_q & ~actVld_q & ~pvld_q;
    end

endmodule

// File: tb/tb_cmac_actv_feeder.sv
// tb_cmac_actv_feeder: directed scenarios plus random traffic. The reference
// model holds the kernel atoms as a queue (head = live kernel) and is compared
// against the DUT on every falling edge.
module tb_cmac_actv_feeder;

    localparam int ATOMC = 64;
    localparam int BPE   = 8;
    localparam int CNT_W = 16;
    localparam int W     = ATOMC * BPE;

    logic              clk;
    logic              rst;
    logic              opEn;
    logic              wtV;
    logic              wtRdy;
    logic [W-1:0]      wtD;
    logic [ATOMC-1:0]  wtM;
    logic              datV;
    logic              datRdy;
    logic [W-1:0]      datD;
    logic [ATOMC-1:0]  datM;
    logic              datEnd;
    logic [W-1:0]      datActvData;
    logic [ATOMC-1:0]  datActvNz;
    logic [ATOMC-1:0]  datActvPvld;
    logic [W-1:0]      wtActvData;
    logic [ATOMC-1:0]  wtActvNz;
    logic [ATOMC-1:0]  wtActvPvld;
    logic [CNT_W-1:0]  stripeCnt;
    logic              idle;

    int checks = 0;
    int errors = 0;

    cmac_actv_feeder #(.ATOMC(ATOMC), .BPE(BPE), .CNT_W(CNT_W)) dut (
        .nvdla_core_clk    (clk),
        .nvdla_core_rst    (rst),
        .op_en             (opEn),
        .wt_in_pvld        (wtV),
        .wt_in_prdy        (wtRdy),
        .wt_in_data        (wtD),
        .wt_in_mask        (wtM),
        .dat_in_pvld       (datV),
        .dat_in_prdy       (datRdy),
        .dat_in_data       (datD),
        .dat_in_mask       (datM),
        .dat_in_stripe_end (datEnd),
        .dat_actv_data     (datActvData),
        .dat_actv_nz       (datActvNz),
        .dat_actv_pvld     (datActvPvld),
        .wt_actv_data      (wtActvData),
        .wt_actv_nz        (wtActvNz),
        .wt_actv_pvld      (wtActvPvld),
        .stripe_cnt        (stripeCnt),
        .feeder_idle       (idle)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [ATOMC-1:0] nzOf(input logic [W-1:0] d, input logic [ATOMC-1:0] m);
        logic [ATOMC-1:0] r;
        r = '0;
        for (int i = 0; i < ATOMC; i++) r[i] = m[i] && (d[i*BPE +: BPE] != 8'h00);
        return r;
    endfunction

    function automatic logic [W-1:0] seqAtom(input int base);
        logic [W-1:0] r;
        for (int i = 0; i < ATOMC; i++) r[i*BPE +: BPE] = 8'(base + i);
        return r;
    endfunction

    function automatic logic [W-1:0] randAtom();
        logic [W-1:0] r;
        for (int i = 0; i < ATOMC; i++)
            r[i*BPE +: BPE] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
        return r;
    endfunction

    function automatic logic [ATOMC-1:0] randMask();
        logic [ATOMC-1:0] a;
        logic [ATOMC-1:0] b;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        return ~(a & b);
    endfunction

    task automatic applyStimulus(input logic en, input logic wv, input logic [W-1:0] wd,
                                 input logic [ATOMC-1:0] wm, input logic dv, input logic [W-1:0] dd,
                                 input logic [ATOMC-1:0] dm, input logic de);
        opEn   = en;
        wtV    = wv;
        wtD    = wd;
        wtM    = wm;
        datV   = dv;
        datD   = dd;
        datM   = dm;
        datEnd = de;
    endtask

    task automatic advanceCycle();
        @(posedge clk);
        #1;
    endtask

    // Reference model: kernel queue where the head is live once promoted.
    typedef struct {
        logic [W-1:0]     data;
        logic [ATOMC-1:0] nz;
    } atom_t;

    atom_t            wq[$];
    bit               headLive = 1'b0;
    logic [W-1:0]     expDat   = '0;
    logic [ATOMC-1:0] expDatNz = '0;
    logic [W-1:0]     expWt    = '0;
    logic [ATOMC-1:0] expWtNz  = '0;
    bit               expPvld  = 1'b0;
    logic [CNT_W-1:0] expCnt   = '0;

    // Compare process: check the DUT against the model, then advance the model with the inputs the next edge will see.
    initial begin
        bit    shadowBusy;
        bit    wFire;
        bit    dFire;
        atom_t a;
        forever begin
            @(negedge clk);
            shadowBusy = (wq.size() >= 2) || (wq.size() == 1 && !headLive);
            checkOutput("wt_in_prdy",    W'(wtRdy),       W'(opEn && !shadowBusy));
            checkOutput("dat_in_prdy",   W'(datRdy),      W'(opEn && headLive));
            checkOutput("dat_actv_data", datActvData,     expDat);
            checkOutput("dat_actv_nz",   W'(datActvNz),   W'(expDatNz));
            checkOutput("dat_actv_pvld", W'(datActvPvld), W'({ATOMC{expPvld}}));
            checkOutput("wt_actv_data",  wtActvData,      expWt);
            checkOutput("wt_actv_nz",    W'(wtActvNz),    W'(expWtNz));
            checkOutput("wt_actv_pvld",  W'(wtActvPvld),  W'({ATOMC{expPvld}}));
            checkOutput("stripe_cnt",    W'(stripeCnt),   W'(expCnt));
            checkOutput("feeder_idle",   W'(idle),        W'(wq.size() == 0 && !expPvld));

            if (rst) begin
                wq.delete();
                headLive = 1'b0;
                expDat = '0; expDatNz = '0; expWt = '0; expWtNz = '0;
                expPvld = 1'b0;
                expCnt = '0;
            end else if (!opEn) begin
                wq.delete();
                headLive = 1'b0;
                expPvld = 1'b0;
                expCnt = '0;
            end else begin
                wFire = wtV && !shadowBusy;
                dFire = datV && headLive;
                expPvld = dFire;
                if (dFire) begin
                    expDat   = datD;
                    expDatNz = nzOf(datD, datM);
                    expWt    = wq[0].data;
                    expWtNz  = wq[0].nz;
                end
                if (dFire && datEnd) begin
                    void'(wq.pop_front());
                    headLive = (wq.size() > 0);
                    expCnt = expCnt + 1'b1;
                end else if (!headLive && wq.size() > 0) begin
                    headLive = 1'b1;
                end
                if (wFire) begin
                    a.data = wtD;
                    a.nz   = nzOf(wtD, wtM);
                    wq.push_back(a);
                end
            end
        end
    end

    // Stimulus: directed scenarios with literal expectations, then random traffic.
    initial begin
        logic [W-1:0]     w0, w1, w2, w3, w4, d9, d10;
        logic [ATOMC-1:0] all1;
        all1 = '1;
        w0 = {ATOMC{8'h01}};
        w1 = {ATOMC{8'h02}};
        w2 = {ATOMC{8'h03}};
        w3 = {ATOMC{8'h33}};
        w4 = {ATOMC{8'h55}};
        d9 = {ATOMC{8'h44}};
        d9[5*BPE +: BPE] = 8'h00;
        d10 = seqAtom(100);

        rst = 1'b1;
        applyStimulus(0, 0, '0, '0, 0, '0, '0, 0);
        repeat (3) advanceCycle();
        checkOutput("reset pvld",  W'(datActvPvld), W'(0));
        checkOutput("reset idle",  W'(idle),        W'(1));
        checkOutput("reset prdy",  W'(datRdy),      W'(0));
        checkOutput("reset cnt",   W'(stripeCnt),   W'(0));
        rst = 1'b0;

        // W0 into an empty feeder
        applyStimulus(1, 1, w0, all1, 0, '0, '0, 0);
        #1;
        checkOutput("c0 wt_in_prdy", W'(wtRdy), W'(1));
        checkOutput("c0 idle",       W'(idle),  W'(1));
        advanceCycle();
        applyStimulus(1, 0, '0, '0, 0, '0, '0, 0);
        #1;
        checkOutput("c1 idle",        W'(idle),   W'(0));
        checkOutput("c1 dat_in_prdy", W'(datRdy), W'(0));
        advanceCycle();
        checkOutput("c2 dat_in_prdy", W'(datRdy), W'(1));

        // D0 issued with W0
        applyStimulus(1, 0, '0, '0, 1, seqAtom(0), all1, 0);
        advanceCycle();
        checkOutput("D0 pvld",    W'(datActvPvld), W'(all1));
        checkOutput("D0 nz",      W'(datActvNz),   W'(64'hFFFF_FFFF_FFFF_FFFE));
        checkOutput("D0 weights", wtActvData,      w0);

        // W1 preloads mid-stripe, stripe ends, D5 follows with no bubble
        applyStimulus(1, 1, w1, all1, 1, seqAtom(10), all1, 0);
        advanceCycle();
        applyStimulus(1, 0, '0, '0, 1, seqAtom(20), all1, 0);
        advanceCycle();
        applyStimulus(1, 0, '0, '0, 1, seqAtom(30), all1, 0);
        advanceCycle();
        applyStimulus(1, 0, '0, '0, 1, seqAtom(40), all1, 1);
        advanceCycle();
        applyStimulus(1, 0, '0, '0, 1, seqAtom(50), all1, 0);
        #1;
        checkOutput("D5 no bubble", W'(datRdy), W'(1));
        advanceCycle();
        checkOutput("D5 weights",    wtActvData,    w1);
        checkOutput("D5 stripe_cnt", W'(stripeCnt), W'(1));
        checkOutput("D5 wt_in_prdy", W'(wtRdy),     W'(1));

        // stripe end with empty shadow while W2 loads: one bubble
        applyStimulus(1, 1, w2, all1, 1, seqAtom(60), all1, 1);
        advanceCycle();
        applyStimulus(1, 0, '0, '0, 1, seqAtom(70), all1, 0);
        #1;
        checkOutput("bubble prdy", W'(datRdy), W'(0));
        advanceCycle();
        checkOutput("bubble pvld",   W'(datActvPvld), W'(0));
        checkOutput("after bubble",  W'(datRdy),      W'(1));
        advanceCycle();
        checkOutput("W2 weights",    wtActvData,    w2);
        checkOutput("W2 stripe_cnt", W'(stripeCnt), W'(2));

        // mask and zero-detect on both sides
        applyStimulus(1, 1, w3, all1 & ~64'h8, 0, '0, '0, 0);
        advanceCycle();
        applyStimulus(1, 0, '0, '0, 1, seqAtom(80), all1, 1);
        advanceCycle();
        applyStimulus(1, 0, '0, '0, 1, d9, all1, 0);
        advanceCycle();
        checkOutput("W3 nz",   W'(wtActvNz),  W'(64'hFFFF_FFFF_FFFF_FFF7));
        checkOutput("D9 nz",   W'(datActvNz), W'(64'hFFFF_FFFF_FFFF_FFDF));
        checkOutput("W3 data", wtActvData,    w3);

        // op_en dropped mid-stripe with a full shadow
        applyStimulus(1, 1, w4, all1, 1, d10, all1, 0);
        advanceCycle();
        applyStimulus(0, 0, '0, '0, 1, seqAtom(110), all1, 0);
        #1;
        checkOutput("off dat_in_prdy", W'(datRdy), W'(0));
        checkOutput("off wt_in_prdy",  W'(wtRdy),  W'(0));
        advanceCycle();
        checkOutput("off pvld",      W'(datActvPvld), W'(0));
        checkOutput("off cnt",       W'(stripeCnt),   W'(0));
        checkOutput("off data hold", datActvData,     d10);
        applyStimulus(1, 0, '0, '0, 1, seqAtom(120), all1, 0);
        #1;
        checkOutput("reenable idle", W'(idle),   W'(1));
        checkOutput("reenable prdy", W'(datRdy), W'(0));
        advanceCycle();
        checkOutput("reenable pvld", W'(datActvPvld), W'(0));

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            applyStimulus(($urandom_range(0, 79) != 0),
                          ($urandom_range(0, 2) == 0), randAtom(), randMask(),
                          ($urandom_range(0, 3) != 0), randAtom(), randMask(),
                          ($urandom_range(0, 4) == 0));
            advanceCycle();
        end
        applyStimulus(1, 0, '0, '0, 0, '0, '0, 0);
        repeat (3) advanceCycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
